// File: rtl/mem_bus_bridge.sv
// Core-to-SRAM bridge: turns level RD/WR requests into timed CE/OE/WE cycles with wait states.
// Optional ready timeout with sticky BUS_ERR is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_bridge #(
  parameter int unsigned WAIT_STATES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CPU_ABUS,
  input  logic [15:0] CPU_DBUS_OUT,
  input  logic        CPU_RD,
  input  logic        CPU_WR,
  output logic [15:0] CPU_DBUS_IN,
  output logic        CPU_STALL,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_DOUT,
  input  logic [15:0] MEM_DIN,
  output logic        MEM_CE,
  output logic        MEM_OE,
  output logic        MEM_WE,
  input  logic        MEM_READY,
  output logic        BUS_ERR
);

  localparam logic [3:0] WaitLast = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic        is_rd_q, is_rd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] rdata_q, rdata_d;
  logic        req_legal;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_q, tmo_d;
  logic       ext_q, ext_d;
  logic       err_q, err_d;
`endif

  assign req_legal = CPU_RD ^ CPU_WR;

  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    rdata_d   = rdata_q;
    CPU_STALL = 1'b0;
    MEM_CE    = 1'b0;
    MEM_OE    = 1'b0;
    MEM_WE    = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
    tmo_d = tmo_q;
    ext_d = ext_q;
    err_d = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_legal) begin
          CPU_STALL = 1'b1;
          addr_d    = CPU_ABUS;
          is_rd_d   = CPU_RD;
          if (CPU_WR) dout_d = CPU_DBUS_OUT;
`ifdef MEM_BUS_TIMEOUT_EN
          tmo_d = '0;
          ext_d = 1'b0;
`endif
          state_d = StSetup;
        end
      end
      StSetup: begin
        CPU_STALL = 1'b1;
        MEM_CE    = 1'b1;
        MEM_OE    = is_rd_q;
        cnt_d     = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        CPU_STALL = 1'b1;
        MEM_CE    = 1'b1;
        MEM_OE    = is_rd_q;
        MEM_WE    = ~is_rd_q;
        // Counter saturates at the last counted cycle; ready extension just holds it there.
        if (cnt_q != WaitLast) begin
          cnt_d = cnt_q + 4'd1;
        end else if (MEM_READY) begin
          state_d = StDone;
          if (is_rd_q) rdata_d = MEM_DIN;
        end
`ifdef MEM_BUS_TIMEOUT_EN
        else if (ext_q) begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == TmoLast) begin
            state_d = StDone;
            err_d   = 1'b1;
            if (is_rd_q) rdata_d = 16'hFFFF;
          end
        end else begin
          ext_d = 1'b1;
        end
`endif
      end
      StDone: begin
        if (!CPU_RD && !CPU_WR) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      is_rd_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_BUS_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_q <= '0;
      ext_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      ext_q <= ext_d;
      err_q <= err_d;
    end
  end

  assign BUS_ERR = err_q;
`else
  assign BUS_ERR = 1'b0;
`endif

  assign CPU_DBUS_IN = rdata_q;
  assign MEM_ADDR    = addr_q;
  assign MEM_DOUT    = dout_q;

endmodule
